calc_arbiter: RTL and testbench
===============================

CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, operand/result width; SHALL match the calculator datapath width.
REQ-002 Parameter: OP_W, default 4, opcode width.
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-007 req_ready  output  2  per-requester command accept.
REQ-008 req0_in1, req0_in2, req1_in1, req1_in2  input  DATA_W each  operands.
REQ-009 req0_opCode, req1_opCode  input  OP_W each  calculator opcode.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_result  output  DATA_W  result of the command in flight, shared by both requesters.
REQ-013 rsp_overflow  output  1  overflow of the command in flight.
REQ-014 rsp_error  output  1  illegal-opcode flag; SHALL be 0 when CALC_ARB_OPCHK_EN is undefined.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be: IDLE, EXEC, RESP.
REQ-017 IDLE: req_ready SHALL be one-hot to the granted requester, or 0 if neither is valid; a handshake (valid&ready) SHALL latch operands, opcode and owner ID, then go to EXEC.
REQ-018 req_ready SHALL be 0 in EXEC and RESP; only one command SHALL be in flight.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the last-grant pointer SHALL update only on a handshake.
REQ-020 EXEC: latched values SHALL drive the calculator; result and overflow SHALL be registered at the end of EXEC (exactly 1 cycle); then go to RESP.
REQ-021 RESP: rsp_valid[owner] SHALL be 1 and the other bit 0; rsp_result and rsp_overflow SHALL stay stable until rsp_ready[owner]=1, then go to IDLE.
REQ-022 Latency: handshake in cycle N SHALL give rsp_valid in cycle N+2; the earliest next accept SHALL be in the cycle after the response handshake.
REQ-023 rsp_ready on the non-owner bit SHALL be ignored.
REQ-024 Opcodes SHALL pass through unmodified: 0000 add, 0001 sub, 0010 mul, 0100 and, 0101 xor, 0110 or, 0111 not in1, 1000 inc, 1001 dec.
REQ-025 A requester deasserting req_valid without a handshake SHALL NOT be penalised; arbitration SHALL be re-evaluated every IDLE cycle.

Reset
REQ-026 On rst_n=0, state SHALL be IDLE and req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_error and busy SHALL all be 0; the last-grant pointer SHALL be 1, so requester 0 wins first.
REQ-027 Reset asserted in EXEC or RESP SHALL drop the in-flight command with no response.

Configuration
REQ-028 Macro CALC_ARB_OPCHK_EN, when defined: opcodes 0011 and 1010-1111 SHALL skip the calculator and respond in RESP with rsp_error=1, rsp_result=0, rsp_overflow=0, at the same latency.
REQ-029 Without CALC_ARB_OPCHK_EN: every opcode SHALL pass to the calculator and rsp_error SHALL be tied to 0.

Structure
REQ-030 Shared package calc_pkg SHALL hold the opcode constants, the DATA_W/OP_W defaults and the FSM state enum.
REQ-031 Exactly one sub-module SHALL be instantiated: the existing calculator (in1, in2, opCode, result, overflow).
REQ-032 Round-robin logic SHALL stay inline.

Verification
REQ-033 Overflow add: req0 sends in1=0x7FFF, in2=0x0002, op 0000 -> rsp_valid[0] at N+2, result 0x8001, overflow=1.
REQ-034 Contention: both valid from reset with req0 AND 0x0FFF&0x0AC3 and req1 inc 0x7FF0 -> grant order req0 then req1; results 0x0AC3 and 0x7FF1.
REQ-035 Backpressure: rsp_ready[0] held 0 for 5 cycles on a dec of 0x8000 -> result 0x7FFF, overflow=1 stay stable; req_ready stays 0 throughout.
REQ-036 Reset mid-op: rst_n low during EXEC -> all outputs 0 immediately; no rsp_valid after release; req0 granted first.
REQ-037 Opcode check: op 1111 with CALC_ARB_OPCHK_EN -> rsp_error=1, result 0; without the macro -> rsp_error=0 and the calculator output is returned.
REQ-038 Fairness: both requesters continuously valid for 10 commands -> strict alternation, 5 grants each.

Source files
------------

// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator arbiter slice:
//   - CALC_DATA_W / CALC_OP_W : default operand and opcode widths
//   - OP_*                    : calculator opcode constants
//   - calc_state_e            : arbiter FSM state encoding
//   - is_illegal_op()         : opcodes the calculator does not implement
//                               (only consulted when CALC_ARB_OPCHK_EN is set)
// ----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_DATA_W = 16;
  localparam int CALC_OP_W   = 4;

  localparam logic [CALC_OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [CALC_OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [CALC_OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [CALC_OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [CALC_OP_W-1:0] OP_XOR = 4'b0101;
  localparam logic [CALC_OP_W-1:0] OP_OR  = 4'b0110;
  localparam logic [CALC_OP_W-1:0] OP_NOT = 4'b0111;
  localparam logic [CALC_OP_W-1:0] OP_INC = 4'b1000;
  localparam logic [CALC_OP_W-1:0] OP_DEC = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } calc_state_e;

  // 0011 and 1010..1111 have no calculator function.
  function automatic logic is_illegal_op(input logic [CALC_OP_W-1:0] op);
    return (op == 4'b0011) || (op >= 4'b1010);
  endfunction

endpackage

// File: rtl/calc_arbiter_calc.sv
// ----------------------------------------------------------------------------
// calc_arbiter_calc
// Combinational calculator datapath. Arithmetic is two's complement; overflow
// flags signed overflow for add/sub/mul/inc/dec and is 0 for logic ops.
// Unimplemented opcodes return result 0, overflow 0.
// Ports:
//   in1, in2  : operands (DATA_W)
//   opCode    : operation select (OP_W)
//   result    : operation result (DATA_W)
//   overflow  : signed overflow of the operation
// ----------------------------------------------------------------------------
module calc_arbiter_calc
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int OP_W   = CALC_OP_W
) (
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [OP_W-1:0]   opCode,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam logic [DATA_W-1:0] ONE     = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic                mul_ovf;

  assign sum   = in1 + in2;
  assign diff  = in1 - in2;
  // Sign-extend to full width so the low 2*DATA_W bits are the signed product.
  assign a_ext = {{DATA_W{in1[DATA_W-1]}}, in1};
  assign b_ext = {{DATA_W{in2[DATA_W-1]}}, in2};
  assign prod  = a_ext * b_ext;
  // Product fits only if the top DATA_W+1 bits are all copies of the sign.
  assign mul_ovf = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (opCode)
      OP_ADD: begin
        result   = sum;
        overflow = (in1[DATA_W-1] == in2[DATA_W-1]) && (sum[DATA_W-1] != in1[DATA_W-1]);
      end
      OP_SUB: begin
        result   = diff;
        overflow = (in1[DATA_W-1] != in2[DATA_W-1]) && (diff[DATA_W-1] != in1[DATA_W-1]);
      end
      OP_MUL: begin
        result   = prod[DATA_W-1:0];
        overflow = mul_ovf;
      end
      OP_AND: result = in1 & in2;
      OP_XOR: result = in1 ^ in2;
      OP_OR:  result = in1 | in2;
      OP_NOT: result = ~in1;
      OP_INC: begin
        result   = in1 + ONE;
        overflow = (in1 == MAX_POS);
      end
      OP_DEC: begin
        result   = in1 - ONE;
        overflow = (in1 == MIN_NEG);
      end
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_arbiter.sv
// ----------------------------------------------------------------------------
// calc_arbiter
// Two-requester round-robin front end for a single calculator. One command is
// in flight at a time: IDLE (arbitrate/accept) -> EXEC (compute, 1 cycle)
// -> RESP (hold response until the owner accepts it).
//
// Handshake semantics (both command and response channels): a transfer
// happens on a rising edge where valid and ready are both 1. The arbiter
// asserts req_ready only in IDLE, one-hot to the granted requester, and never
// depends on it being held; a requester may drop req_valid before a transfer
// without losing its turn. rsp_valid[owner] stays 1 with stable data until
// rsp_ready[owner]=1; rsp_ready of the other requester is ignored.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]: per-requester command handshake
//   req{0,1}_in1/in2/opCode : per-requester operands and opcode
//   rsp_valid/rsp_ready[1:0]: per-requester response handshake
//   rsp_result/overflow     : shared response data
//   rsp_error               : illegal opcode flag (0 unless CALC_ARB_OPCHK_EN)
//   busy                    : FSM not in IDLE
//   dbg_state               : current FSM state
//
// Build option: define CALC_ARB_OPCHK_EN to answer opcodes 0011 and
// 1010..1111 with rsp_error=1 and a zero result instead of the calculator.
// ----------------------------------------------------------------------------
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int OP_W   = CALC_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [OP_W-1:0]   req0_opCode,
  input  logic [OP_W-1:0]   req1_opCode,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_error,
  output logic              busy,
  output calc_state_e       dbg_state
);

  calc_state_e       state_q, state_d;
  logic              last_q;   // requester granted most recently
  logic              owner_q;  // requester of the command in flight
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] in1_q, in2_q, res_q;
  logic [OP_W-1:0]   op_q;
  logic              ovf_q;
  logic [DATA_W-1:0] calc_res;
  logic              calc_ovf;

  // With both valid the requester not served last wins; otherwise whichever
  // one is valid. Evaluated fresh every IDLE cycle.
  always_comb begin
    if (req_valid[0] && req_valid[1]) grant = ~last_q;
    else                              grant = req_valid[1];
  end

  assign accept = (state_q == IDLE) && (|req_valid);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant ? 2'b10 : 2'b01;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  // Command capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;  // so requester 0 wins the first contention
      owner_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= grant;
        last_q  <= grant;
        in1_q   <= grant ? req1_in1    : req0_in1;
        in2_q   <= grant ? req1_in2    : req0_in2;
        op_q    <= grant ? req1_opCode : req0_opCode;
      end
      if (state_q == EXEC) begin
`ifdef CALC_ARB_OPCHK_EN
        if (is_illegal_op(op_q)) begin
          res_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          res_q <= calc_res;
          ovf_q <= calc_ovf;
        end
`else
        res_q <= calc_res;
        ovf_q <= calc_ovf;
`endif
      end
    end
  end

`ifdef CALC_ARB_OPCHK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_q <= 1'b0;
    else if (state_q == EXEC)   err_q <= is_illegal_op(op_q);
  end
  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  assign rsp_result   = res_q;
  assign rsp_overflow = ovf_q;

  calc_arbiter_calc #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_calc (
    .in1      (in1_q),
    .in2      (in2_q),
    .opCode   (op_q),
    .result   (calc_res),
    .overflow (calc_ovf)
  );

endmodule

// File: tb/tb_calc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_calc_arbiter
// Directed bench for calc_arbiter. Inputs change on the falling edge and
// outputs are read 1 time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_calc_arbiter;
  import calc_pkg::*;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [3:0]   req0_opCode = '0, req1_opCode = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = '0;
  logic [W-1:0] rsp_result;
  logic         rsp_overflow;
  logic         rsp_error;
  logic         busy;
  calc_state_e  dbg_state;

  calc_arbiter #(.DATA_W(W), .OP_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_in1     (req0_in1),
    .req0_in2     (req0_in2),
    .req1_in1     (req1_in1),
    .req1_in2     (req1_in2),
    .req0_opCode  (req0_opCode),
    .req1_opCode  (req1_opCode),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_error    (rsp_error),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

`ifdef CALC_ARB_OPCHK_EN
  localparam logic ILLEGAL_ERR = 1'b1;
`else
  localparam logic ILLEGAL_ERR = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int id);
    return (id != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op);
    if (id == 0) begin
      req0_in1 = a; req0_in2 = b; req0_opCode = op;
    end else begin
      req1_in1 = a; req1_in2 = b; req1_opCode = op;
    end
  endtask

  task automatic check_rsp(input string tag, input int id, input logic eo, input logic ee);
    logic [W-1:0] e;
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(onehot(id)));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_result"}, 32'(rsp_result), 32'(e));
    end
    check_eq({tag, "_overflow"}, 32'(rsp_overflow), 32'(eo));
    check_eq({tag, "_error"}, 32'(rsp_error), 32'(ee));
  endtask

  // Single command from IDLE to IDLE with latency checks at N, N+1, N+2.
  task automatic run_cmd(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input logic [W-1:0] er,
                         input logic eo, input logic ee, input string tag);
    set_req(id, a, b, op);
    req_valid = onehot(id);
    #1 check_eq({tag, "_accept"}, 32'(req_ready), 32'(onehot(id)));
    exp_q.push_back(er);
    @(negedge clk); req_valid = 2'b00; #1;
    check_eq({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_exec_novalid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    check_rsp(tag, id, eo, ee);
    rsp_ready = onehot(id);
    @(negedge clk); rsp_ready = 2'b00; #1;
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_novalid"}, 32'(rsp_valid), 32'd0);
  endtask

  // Both requesters valid at once; requester 0 expected first (pointer = 1).
  task automatic run_pair(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] op0,
                          input logic [W-1:0] e0, input logic o0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] op1,
                          input logic [W-1:0] e1, input logic o1, input string tag);
    set_req(0, a0, b0, op0);
    set_req(1, a1, b1, op1);
    req_valid = 2'b11;
    #1 check_eq({tag, "_grant0"}, 32'(req_ready), 32'b01);
    exp_q.push_back(e0);
    @(negedge clk); req_valid = 2'b10; #1;
    check_eq({tag, "_exec_noready"}, 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check_rsp({tag, "_r0"}, 0, o0, 1'b0);
    check_eq({tag, "_resp_noready"}, 32'(req_ready), 32'd0);
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 2'b00; #1;
    check_eq({tag, "_grant1"}, 32'(req_ready), 32'b10);
    exp_q.push_back(e1);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    check_rsp({tag, "_r1"}, 1, o1, 1'b0);
    rsp_ready = 2'b10;
    @(negedge clk); rsp_ready = 2'b00; #1;
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_result"}, 32'(rsp_result), 32'd0);
    check_eq({tag, "_overflow"}, 32'(rsp_overflow), 32'd0);
    check_eq({tag, "_error"}, 32'(rsp_error), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1, exp_id;

    // reset: valids are 0, so req_ready must read 0 too
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // contention from reset: req0 AND then req1 INC
    run_pair(16'h0FFF, 16'h0AC3, OP_AND, 16'h0AC3, 1'b0,
             16'h7FF0, 16'h0000, OP_INC, 16'h7FF1, 1'b0, "contend");

    // signed overflow on add
    run_cmd(0, 16'h7FFF, 16'h0002, OP_ADD, 16'h8001, 1'b1, 1'b0, "add_ovf");

    // backpressure: dec 0x8000 held 5 cycles, req1 waiting the whole time
    set_req(0, 16'h8000, 16'h0000, OP_DEC);
    req_valid = 2'b01;
    #1 check_eq("bp_accept", 32'(req_ready), 32'b01);
    exp_q.push_back(16'h7FFF);
    @(negedge clk);
    set_req(1, 16'h00FF, 16'h0F0F, OP_XOR);
    req_valid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i == 2) ? 2'b10 : 2'b00;  // non-owner ready must not complete it
      #1;
      check_eq("bp_hold_valid", 32'(rsp_valid), 32'b01);
      check_eq("bp_hold_result", 32'(rsp_result), 32'h7FFF);
      check_eq("bp_hold_ovf", 32'(rsp_overflow), 32'd1);
      check_eq("bp_hold_noready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1 check_rsp("bp", 0, 1'b1, 1'b0);
    rsp_ready = 2'b01;
    #1 check_eq("bp_ack_noready", 32'(req_ready), 32'd0);
    @(negedge clk); rsp_ready = 2'b00;
    #1 check_eq("bp_next_grant", 32'(req_ready), 32'b10);
    exp_q.push_back(16'h0FF0);
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    check_rsp("bp_xor", 1, 1'b0, 1'b0);
    rsp_ready = 2'b10;
    @(negedge clk); rsp_ready = 2'b00;

    // assorted operations
    run_cmd(0, 16'h0100, 16'h0100, OP_MUL, 16'h0000, 1'b1, 1'b0, "mul_ovf");
    run_cmd(1, 16'h00FF, 16'h1234, OP_NOT, 16'hFF00, 1'b0, 1'b0, "not");
    run_cmd(0, 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b0, "sub_ovf");

    // reset during EXEC drops the command (last grant is req1 here)
    set_req(1, 16'h0009, 16'h0003, OP_SUB);
    req_valid = 2'b10;
    #1 check_eq("rst_mid_accept", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check_eq("rst_mid_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    run_pair(16'h1200, 16'h0034, OP_OR, 16'h1234, 1'b0,
             16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, "post_rst");

    // unimplemented opcode
    run_cmd(0, 16'h1234, 16'h5678, 4'b1111, 16'h0000, 1'b0, ILLEGAL_ERR, "op1111");

    // fairness: both valid for 10 commands; req0 was granted last
    set_req(0, 16'h0003, 16'h0004, OP_MUL);
    set_req(1, 16'h0001, 16'hFFFF, OP_ADD);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    cnt0 = 0; cnt1 = 0; exp_id = 1;
    for (int k = 0; k < 10; k++) begin
      #1 check_eq("fair_grant", 32'(req_ready), 32'(onehot(exp_id)));
      if (req_ready == 2'b01) cnt0++;
      if (req_ready == 2'b10) cnt1++;
      exp_q.push_back((exp_id != 0) ? 16'h0000 : 16'h000C);
      @(negedge clk);
      @(negedge clk); #1;
      check_rsp("fair", exp_id, 1'b0, 1'b0);
      @(negedge clk);
      exp_id = 1 - exp_id;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    check_eq("fair_cnt0", 32'(cnt0), 32'd5);
    check_eq("fair_cnt1", 32'(cnt1), 32'd5);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
